imm_encoder: RTL
================

Name: imm_encoder

Overview:
- Streaming instruction encoder; the inverse of the immediate generator.
- Takes decoded fields (opcode, registers, funct, 32-bit immediate) and scatters the immediate into the RISC-V bit positions, producing a 32-bit instruction word.
- Two-stage valid/ready pipeline with a target-address counter; used by the testbench/boot loader to fill instruction memory.
- Flags immediates that the selected format cannot represent.

Parameters:
- ADDR_W, 32, width of the output write address.
- BASE_ADDR, 0, address of the first emitted word; also the value restored by reset and clear.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush: empties pipeline, restores out_addr to BASE_ADDR.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept the bundle this cycle.
- in_opcode  input  7  instruction opcode.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_funct3  input  3  funct3.
- in_funct7  input  7  funct7; used only by default/R packing.
- in_imm  input  32  immediate, two's complement, byte offset for branches.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  consumer accepts the word.
- out_inst  output  32  encoded instruction.
- out_addr  output  ADDR_W  memory address for out_inst.
- out_err  output  1  immediate not representable; qualifies out_inst.
- err_count  output  16  saturating count of emitted words with out_err=1.

Behaviour:
- Reset, and clear when reset=0: s1_valid=0, s2_valid=0, out_valid=0, out_inst=0, out_err=0, out_addr=BASE_ADDR. err_count=0 on reset only; clear leaves it unchanged.
- Input handshake occurs when in_valid && in_ready.
  - in_ready = !clear && (!s1_valid || s2_can_load).
  - s2_can_load = !s2_valid || out_ready.
- Output handshake occurs when out_valid && out_ready.
  - On each output handshake, out_addr += 4, wrapping modulo 2^ADDR_W.
- Stage 1 registers the raw fields. Stage 2 registers the encoded word and the error flag.
  - Latency from input handshake to out_valid is 2 cycles with no stall.
  - Throughput is 1 word/cycle.
  - Both stages hold their contents while stalled. out_* are stable while out_valid && !out_ready.
- Encoding. opc, f3 and f7 denote in_opcode, in_funct3 and in_funct7.
  - 0000011 load and 0010011 I-ALU: inst = {imm[11:0], rs1, f3, rd, opc}. err when imm[31:11] is not all-equal (outside -2048..2047).
  - 0100011 S: inst = {imm[11:5], rs2, rs1, f3, imm[4:0], opc}. Same err rule as I.
  - 1100011 B: inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc}. err when imm[31:12] is not all-equal, or when imm[0]=1.
  - Any other opcode: R packing, inst = {f7, rs2, rs1, f3, rd, opc}. imm is ignored; err=0.
- On err, the word is still emitted using the truncated low bits.
- err_count increments on each output handshake with out_err=1 and saturates at 0xFFFF.
- Round-trip invariant: for legal I/S/B inputs, the immediate generator applied to out_inst returns in_imm exactly.
- clear together with in_valid: clear wins and no input handshake occurs. A word at the output is dropped and out_addr does not advance.
- reset asserted mid-stream: all in-flight words are discarded. out_valid is 0 on the following cycle.

Decomposition:
- Shared package rv_enc_pkg:
  - Opcode localparams OPC_LOAD, OPC_IALU, OPC_STORE, OPC_BRANCH.
  - Packed struct enc_fields_t holding opcode, rd, rs1, rs2, funct3, funct7, imm.
  - Format enum FMT_I, FMT_S, FMT_B, FMT_R.
- One combinational sub-module, imm_pack: fields -> {inst, err}. It is instantiated between stage 1 and stage 2. The top level holds the handshake, the registers and the counters.

Test Plan:
- I-type, opc=0010011, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF, out_ready=1 -> out_inst=0xFFF00093, out_err=0, out_addr=0, out_valid two cycles after accept.
- S-type, opc=0100011, rs2=2, rs1=0, f3=010, imm=8 -> 0x00202423. B-type, opc=1100011, rs1=rs2=0, f3=0, imm=-4 -> 0xFE000EE3. Back-to-back issue -> out_addr 0, 4, 8 on consecutive cycles.
- Errors: I-type imm=2048, rd=1 -> out_inst=0x80000093, out_err=1. B-type imm=3 -> out_err=1. err_count reaches 2 after both handshakes.
- Backpressure: 4 words streamed with out_ready held 0 for 5 cycles -> in_ready drops once both stages are full, no word lost or duplicated, out_* stable during the stall, addresses 0, 4, 8, 12 in order after release.
- clear with a full pipeline and in_valid=1 -> out_valid=0 next cycle, no acceptance that cycle, next word emitted at BASE_ADDR, err_count retained. reset mid-stream -> all outputs at their reset values.
- Wrap: ADDR_W=4, BASE_ADDR=12 -> out_addr sequence 12, 0, 4. Randomised legal I/S/B bundles passed through the immediate generator -> recovered immediate equals in_imm for every bundle.

Source files
------------

// File: rtl/rv_enc_pkg.sv
// rtl/rv_enc_pkg.sv - opcodes, field bundle and format helpers for the instruction encoder
package rv_enc_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FMT_I = 2'd0,
    FMT_S = 2'd1,
    FMT_B = 2'd2,
    FMT_R = 2'd3
  } fmt_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_fields_t;

  function automatic fmt_t fmt_of(input logic [6:0] opcode);
    fmt_t f;
    case (opcode)
      OPC_LOAD, OPC_IALU: f = FMT_I;
      OPC_STORE:          f = FMT_S;
      OPC_BRANCH:         f = FMT_B;
      default:            f = FMT_R;
    endcase
    return f;
  endfunction

  // A value fits an N-bit signed field when every bit above N-2 matches the sign.
  function automatic logic fits_simm12(input logic [31:0] imm);
    return (&imm[31:11]) | ~(|imm[31:11]);
  endfunction

  function automatic logic fits_simm13(input logic [31:0] imm);
    return (&imm[31:12]) | ~(|imm[31:12]);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - combinational scatter of decoded fields into a RISC-V instruction word
module imm_pack
  import rv_enc_pkg::*;
(
  input  enc_fields_t fields,
  output logic [31:0] inst,
  output logic        err
);

  fmt_t        fmt;
  logic [31:0] imm;

  assign fmt = fmt_of(fields.opcode);
  assign imm = fields.imm;

  // Out-of-range immediates still produce a word built from the truncated low bits.
  always_comb begin
    inst = '0;
    err  = 1'b0;
    case (fmt)
      FMT_I: begin
        inst = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
        err  = !fits_simm12(imm);
      end
      FMT_S: begin
        inst = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0], fields.opcode};
        err  = !fits_simm12(imm);
      end
      FMT_B: begin
        inst = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                imm[4:1], imm[11], fields.opcode};
        err  = !fits_simm13(imm) || imm[0];
      end
      default: begin
        inst = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
        err  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - two-stage streaming instruction encoder with write-address counter
module imm_encoder
  import rv_enc_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [15:0]       err_count
);

  logic        s1_valid;
  enc_fields_t s1_fields;
  logic        s2_valid;
  logic        s2_can_load;
  logic        in_hs;
  logic        out_hs;
  logic [31:0] pack_inst;
  logic        pack_err;

  assign s2_can_load = !s2_valid || out_ready;
  assign in_ready    = !clear && (!s1_valid || s2_can_load);
  assign in_hs       = in_valid && in_ready;
  assign out_hs      = s2_valid && out_ready;
  assign out_valid   = s2_valid;

  imm_pack u_pack (
    .fields (s1_fields),
    .inst   (pack_inst),
    .err    (pack_err)
  );

  // Stage 1: raw field bundle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      s1_valid  <= 1'b0;
      s1_fields <= '0;
    end else if (in_hs) begin
      s1_valid         <= 1'b1;
      s1_fields.opcode <= in_opcode;
      s1_fields.rd     <= in_rd;
      s1_fields.rs1    <= in_rs1;
      s1_fields.rs2    <= in_rs2;
      s1_fields.funct3 <= in_funct3;
      s1_fields.funct7 <= in_funct7;
      s1_fields.imm    <= in_imm;
    end else if (s2_can_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: encoded word; holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      s2_valid <= 1'b0;
      out_inst <= '0;
      out_err  <= 1'b0;
    end else if (s2_can_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_inst <= pack_inst;
        out_err  <= pack_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      out_addr <= BASE_ADDR;
    end else if (out_hs) begin
      out_addr <= out_addr + ADDR_W'(4);
    end
  end

  // A word dropped by clear is not counted; clear leaves the tally intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (!clear && out_hs && out_err && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule
